// File: rtl/dlsc_pcie_s6_tlp_arbiter_pkg.sv
// Shared definitions for the PCIe TX TLP arbiter: FSM states and the
// index-width helper used to size the grant and round-robin pointer.
package dlsc_pcie_s6_tlp_arbiter_pkg;

    // ST_IDLE: no grant held; ST_GRANT: output locked to one source until its last beat.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Bits needed to index n sources (never less than 1).
    function automatic int dlsc_pcie_s6_tlp_arbiter_log2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/dlsc_pcie_s6_tlp_arbiter_if.sv
// Bundle of the per-source input streams, the merged TX stream and the
// arbiter status signals. The arbiter uses the slave view; whatever drives
// the sources and the TX core uses the master view.
interface dlsc_pcie_s6_tlp_arbiter_if #(
    parameter int SOURCES = 3,
    parameter int WIDTH   = 32
);
    logic [SOURCES-1:0]       src_en;
    logic [SOURCES-1:0]       in_ready;
    logic [SOURCES-1:0]       in_valid;
    logic [SOURCES*WIDTH-1:0] in_data;
    logic [SOURCES-1:0]       in_last;
    logic                     out_ready;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic                     out_last;
    logic [2:0]               grant_src;
    logic                     busy;

    modport master (
        output src_en, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, grant_src, busy
    );

    modport slave (
        input  src_en, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, grant_src, busy
    );
endinterface

// File: rtl/dlsc_rvh_decoupler.sv
// Two-entry ready/valid skid buffer. Both in_ready and the output side come
// straight from flops, so neither direction has a combinational path through
// this stage. Output always presents the head (oldest) entry.
module dlsc_rvh_decoupler #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             in_ready,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);
    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             push;
    logic             pop;

    // Work out push/pop and shuffle entries so the head always holds the oldest beat.
    always_comb begin
        push    = in_valid && (count_q != 2'd2);
        pop     = out_ready && (count_q != 2'd0);
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({push, pop})
            2'b10: begin
                count_d = count_q + 2'd1;
                if (count_q == 2'd0) begin
                    head_d = in_data;
                end else begin
                    tail_d = in_data;
                end
            end
            2'b01: begin
                count_d = count_q - 2'd1;
                head_d  = tail_q;
            end
            2'b11: begin
                // Only reachable with exactly one entry: it leaves, the new beat becomes head.
                head_d = in_data;
            end
            default: begin
            end
        endcase
    end

    // Storage registers; reset empties the stage and clears the presented data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
endmodule

// File: rtl/dlsc_pcie_s6_tlp_arbiter.sv
// Packet-atomic round-robin arbiter merging several TLP streams onto the
// Spartan-6 PCIe TX port. A granted source keeps the output until its last
// beat is accepted; a registered skid stage isolates the core's ready.
module dlsc_pcie_s6_tlp_arbiter
    import dlsc_pcie_s6_tlp_arbiter_pkg::*;
#(
    parameter int SOURCES = 3,
    parameter int WIDTH   = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    dlsc_pcie_s6_tlp_arbiter_if.slave      bus
);
    localparam int            GW        = dlsc_pcie_s6_tlp_arbiter_log2(SOURCES);
    localparam logic [GW-1:0] PTR_RESET = GW'(SOURCES - 1);

    state_t           st_q, st_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [GW-1:0]    ptr_q, ptr_d;
    logic [SOURCES-1:0] req;
    logic [WIDTH-1:0] data_arr [SOURCES];
    logic             sel_valid;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;
    logic             accept;
    logic             dec_in_ready;
    logic             dec_in_valid;
    logic [WIDTH:0]   dec_in_data;
    logic             dec_out_valid;
    logic [WIDTH:0]   dec_out_data;

    // First requesting source found searching circularly from the one after p.
    function automatic logic [GW-1:0] rr_select(input logic [SOURCES-1:0] r,
                                                 input logic [GW-1:0]      p);
        logic [GW-1:0] pick;
        logic [GW-1:0] idx_w;
        int            idx;
        pick = p;
        for (int k = SOURCES; k >= 1; k--) begin
            idx   = (int'(p) + k) % SOURCES;
            idx_w = GW'(idx);
            if (r[idx_w]) begin
                pick = idx_w;
            end
        end
        return pick;
    endfunction

    for (genvar i = 0; i < SOURCES; i++) begin : g_unpack
        assign data_arr[i] = bus.in_data[i*WIDTH +: WIDTH];
    end

    // Steer the granted source into the skid stage and decide grant/release.
    always_comb begin
        req          = bus.in_valid & bus.src_en;
        sel_valid    = bus.in_valid[grant_q];
        sel_last     = bus.in_last[grant_q];
        sel_data     = data_arr[grant_q];
        dec_in_valid = (st_q == ST_GRANT) && sel_valid;
        dec_in_data  = {sel_last, sel_data};
        accept       = dec_in_valid && dec_in_ready;
        st_d         = st_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        case (st_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d = rr_select(req, ptr_q);
                    st_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (accept && sel_last) begin
                    ptr_d = grant_q;
                    st_d  = ST_IDLE;
                end
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    // Arbiter state; reset points ptr at the last source so source 0 is searched first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q    <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_RESET;
        end else begin
            st_q    <= st_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    dlsc_rvh_decoupler #(
        .WIDTH (WIDTH + 1)
    ) u_out_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_ready  (dec_in_ready),
        .in_valid  (dec_in_valid),
        .in_data   (dec_in_data),
        .out_ready (bus.out_ready),
        .out_valid (dec_out_valid),
        .out_data  (dec_out_data)
    );

    assign bus.in_ready  = ((st_q == ST_GRANT) && dec_in_ready) ? (SOURCES'(1) << grant_q) : '0;
    assign bus.out_valid = dec_out_valid;
    assign bus.out_last  = dec_out_data[WIDTH];
    assign bus.out_data  = dec_out_data[WIDTH-1:0];
    assign bus.grant_src = 3'(grant_q);
    assign bus.busy      = (st_q == ST_GRANT) || dec_out_valid;
endmodule

// File: tb/tb_dlsc_pcie_s6_tlp_arbiter.sv
// Bench for the TLP arbiter. Sources are modelled as per-source beat queues;
// the expected output stream is the round-robin concatenation of whole
// packets, starting from source 0 after reset and skipping empty sources.
module tb_dlsc_pcie_s6_tlp_arbiter;
    localparam int SOURCES = 3;
    localparam int WIDTH   = 32;
    localparam int DEPTH   = 64;
    localparam int LOGSZ   = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    dlsc_pcie_s6_tlp_arbiter_if #(.SOURCES(SOURCES), .WIDTH(WIDTH)) bus ();

    dlsc_pcie_s6_tlp_arbiter #(.SOURCES(SOURCES), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH:0] beatMem [SOURCES][DEPTH];
    int             head    [SOURCES];
    int             tail    [SOURCES];
    bit             midPacket [SOURCES];
    logic [SOURCES-1:0] srcEnV;
    bit             gapEn;
    int             readyMode;
    logic [WIDTH:0] logMem [LOGSZ];
    int             logCyc [LOGSZ];
    int             nLog;
    logic [WIDTH:0] expMem [LOGSZ];
    int             nExp;
    int             cyc, inCount, outCount, firstValidCyc, firstReadyCyc;
    bit             sawFull;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clearModel();
        for (int s = 0; s < SOURCES; s++) begin
            head[s]      = 0;
            tail[s]      = 0;
            midPacket[s] = 1'b0;
        end
        nLog = 0; nExp = 0; cyc = 0; inCount = 0; outCount = 0;
        firstValidCyc = -1; firstReadyCyc = -1;
        srcEnV = '1; gapEn = 1'b0; readyMode = 0; sawFull = 1'b0;
    endtask

    task automatic addPacket(input int s, input int len, input logic [WIDTH-1:0] base);
        logic [WIDTH-1:0] d;
        for (int b = 0; b < len; b++) begin
            d = (base != '0) ? base + WIDTH'(b) : {4'(s), 28'($urandom)};
            beatMem[s][tail[s]] = {(b == len - 1), d};
            tail[s]++;
        end
    endtask

    // Packet-level reference: round robin over sources with queued packets.
    task automatic buildExpected();
        int idx [SOURCES];
        int p;
        bit found;
        logic [WIDTH:0] b;
        for (int s = 0; s < SOURCES; s++) idx[s] = head[s];
        nExp = 0;
        p = SOURCES - 1;
        for (int n = 0; n < SOURCES * DEPTH; n++) begin
            found = 1'b0;
            for (int k = 1; k <= SOURCES && !found; k++) begin
                if (idx[(p + k) % SOURCES] < tail[(p + k) % SOURCES]) begin
                    found = 1'b1;
                    p = (p + k) % SOURCES;
                end
            end
            if (!found) break;
            do begin
                b = beatMem[p][idx[p]];
                idx[p]++;
                expMem[nExp] = b;
                nExp++;
            end while (!b[WIDTH]);
        end
    endtask

    function automatic bit anyPending();
        bit r = 1'b0;
        for (int s = 0; s < SOURCES; s++) if (head[s] < tail[s]) r = 1'b1;
        return r;
    endfunction

    // One clock: drive sources and core ready, clock, then score handshakes and invariants.
    task automatic applyStimulus();
        logic [SOURCES-1:0] vld, acc;
        logic               oacc, stall, midAny;
        logic [WIDTH+1:0]   prevOut;
        for (int s = 0; s < SOURCES; s++) begin
            logic [WIDTH:0] b;
            b = (head[s] < tail[s]) ? beatMem[s][head[s]] : '0;
            vld[s] = (head[s] < tail[s]) && !(gapEn && midPacket[s] && ($urandom_range(0, 3) == 0));
            bus.in_valid[s] = vld[s];
            bus.in_last[s]  = b[WIDTH];
            bus.in_data[s*WIDTH +: WIDTH] = b[WIDTH-1:0];
        end
        case (readyMode)
            1:       bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            2:       bus.out_ready = ($urandom_range(0, 9) < 7);
            default: bus.out_ready = 1'b1;
        endcase
        bus.src_en = srcEnV;
        if ((|vld) && firstValidCyc < 0) firstValidCyc = cyc;
        acc     = vld & bus.in_ready;
        oacc    = bus.out_valid && bus.out_ready;
        stall   = bus.out_valid && !bus.out_ready;
        prevOut = {bus.out_valid, bus.out_last, bus.out_data};
        @(posedge clk);
        #1;
        cyc++;
        for (int s = 0; s < SOURCES; s++) begin
            if (acc[s]) begin
                midPacket[s] = !beatMem[s][head[s]][WIDTH];
                head[s]++;
                inCount++;
            end
        end
        if (oacc) begin
            if (nLog < LOGSZ) begin
                logMem[nLog] = prevOut[WIDTH:0];
                logCyc[nLog] = cyc;
            end
            nLog++;
            outCount++;
        end
        if ((|bus.in_ready) && firstReadyCyc < 0) firstReadyCyc = cyc;
        if (inCount - outCount == 2) sawFull = 1'b1;
        midAny = 1'b0;
        for (int s = 0; s < SOURCES; s++) if (midPacket[s]) midAny = 1'b1;
        if (stall) checkOutput("hold_stable", {bus.out_valid, bus.out_last, bus.out_data}, prevOut);
        checkOutput("ready_onehot", ($countones(bus.in_ready) <= 1), 1);
        if (midAny) checkOutput("ready_vs_fill", |bus.in_ready, ((inCount - outCount) < 2));
    endtask

    task automatic applyReset(input int n);
        rst_n = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        clearModel();
    endtask

    task automatic drain(input int maxCyc);
        int n = 0;
        while ((nLog < nExp || anyPending()) && n < maxCyc) begin
            applyStimulus();
            n++;
        end
        repeat (3) applyStimulus();
    endtask

    task automatic compareLog(input string tag);
        checkOutput($sformatf("%s_count", tag), nLog, nExp);
        for (int i = 0; i < nExp && i < nLog && i < LOGSZ; i++)
            checkOutput($sformatf("%s_beat%0d", tag, i), logMem[i], expMem[i]);
    endtask

    initial begin
        int n;
        bus.src_en    = '0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.in_last   = '0;
        bus.out_ready = 1'b0;
        clearModel();

        $display("[TB] reset state");
        applyReset(2);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_out_data",  bus.out_data, 0);
        checkOutput("rst_out_last",  bus.out_last, 0);
        checkOutput("rst_in_ready",  bus.in_ready, 0);
        checkOutput("rst_busy",      bus.busy, 0);
        checkOutput("rst_grant",     bus.grant_src, 0);
        rst_n = 1'b1;

        $display("[TB] single source 3-beat packet");
        applyReset(1);
        rst_n = 1'b1;
        addPacket(1, 3, 32'hA0);
        buildExpected();
        drain(40);
        compareLog("single");
        checkOutput("single_ready_latency", firstReadyCyc - firstValidCyc, 1);
        checkOutput("single_consec1", logCyc[1] - logCyc[0], 1);
        checkOutput("single_consec2", logCyc[2] - logCyc[1], 1);
        checkOutput("single_grant", bus.grant_src, 1);

        $display("[TB] three sources, 2-beat packets");
        applyReset(1);
        rst_n = 1'b1;
        for (int s = 0; s < SOURCES; s++) begin
            addPacket(s, 2, '0);
            addPacket(s, 2, '0);
        end
        buildExpected();
        drain(80);
        compareLog("rr");
        for (int i = 0; i < nLog - 1 && i < LOGSZ - 1; i++)
            if (logMem[i][WIDTH]) checkOutput("rr_bubble", logCyc[i+1] - logCyc[i], 2);

        $display("[TB] backpressure on 6-beat packet");
        applyReset(1);
        rst_n = 1'b1;
        readyMode = 1;
        addPacket(2, 6, 32'hB0);
        buildExpected();
        drain(60);
        compareLog("bp");
        checkOutput("bp_filled_two", sawFull, 1);

        $display("[TB] src_en dropped mid-packet");
        applyReset(1);
        rst_n = 1'b1;
        addPacket(0, 3, 32'hC0);
        addPacket(0, 2, 32'hC8);
        addPacket(1, 2, 32'hD0);
        for (int i = 0; i < 3; i++) expMem[i] = beatMem[0][i];
        for (int i = 0; i < 2; i++) expMem[3 + i] = beatMem[1][i];
        nExp = 5;
        n = 0;
        while (!midPacket[0] && n < 20) begin
            applyStimulus();
            n++;
        end
        checkOutput("en_started", midPacket[0], 1);
        srcEnV[0] = 1'b0;
        repeat (30) applyStimulus();
        compareLog("en");
        checkOutput("en_src0_waiting", head[0], 3);

        $display("[TB] single-beat packets on sources 0 and 2");
        applyReset(1);
        rst_n = 1'b1;
        addPacket(0, 1, 32'hE0);
        addPacket(2, 1, 32'hF0);
        addPacket(0, 1, 32'hE1);
        addPacket(2, 1, 32'hF1);
        buildExpected();
        drain(40);
        compareLog("onebeat");

        $display("[TB] reset mid-packet");
        applyReset(1);
        rst_n = 1'b1;
        addPacket(0, 4, 32'h70);
        n = 0;
        while (head[0] < 1 && n < 20) begin
            applyStimulus();
            n++;
        end
        checkOutput("midrst_started", head[0], 1);
        applyReset(1);
        checkOutput("midrst_out_valid", bus.out_valid, 0);
        checkOutput("midrst_busy", bus.busy, 0);
        checkOutput("midrst_in_ready", bus.in_ready, 0);
        rst_n = 1'b1;
        addPacket(1, 2, 32'h90);
        addPacket(0, 2, 32'h80);
        buildExpected();
        drain(40);
        compareLog("midrst");

        $display("[TB] randomized traffic");
        applyReset(1);
        rst_n = 1'b1;
        gapEn = 1'b1;
        readyMode = 2;
        for (int s = 0; s < SOURCES; s++)
            for (int p = 0; p < 10; p++)
                if ($urandom_range(0, 3) != 0) addPacket(s, $urandom_range(1, 5), '0);
        buildExpected();
        drain(3000);
        compareLog("rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
